data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving backing RAM size in 32-bit words (power of two, >=4).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving wait states inserted per access (0..15).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 The block SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 The block SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr  input  32  byte address.
REQ-009 The block SHALL have port req_wdata  input  32  write data.
REQ-010 The block SHALL have port req_be  input  4  byte enables for writes; bit i covers bits [8i+7:8i].
REQ-011 The block SHALL have port resp_valid  output  1  response available.
REQ-012 The block SHALL have port resp_ready  input  1  initiator consumes the response.
REQ-013 The block SHALL have port resp_rdata  output  32  read data, 0 for writes and errors.
REQ-014 The block SHALL have port resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1, latching we, addr, wdata, and be, and loading the wait counter with WAIT_CYCLES.
REQ-017 On acceptance, the FSM SHALL go to WAIT if WAIT_CYCLES>0, else directly to RESP.
REQ-018 In WAIT, the counter SHALL decrement each cycle; the edge on which it reaches 0 SHALL move the FSM to RESP.
REQ-019 The RAM access SHALL happen on the edge entering RESP: a write updates enabled bytes only, and a read registers the full word into resp_rdata.
REQ-020 resp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-021 In RESP, resp_valid, resp_rdata, and resp_err SHALL hold stable until an edge with resp_ready=1; that edge SHALL return the FSM to IDLE and clear resp_valid, resp_rdata, and resp_err to 0.
REQ-022 req_valid SHALL be ignored outside IDLE; one transaction is outstanding at most, and the minimum period is WAIT_CYCLES+2 cycles.
REQ-023 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2].
REQ-024 Error SHALL be flagged when req_addr[1:0]!=0 or req_addr>=DEPTH_WORDS*4.
REQ-025 On error, no RAM write SHALL occur, resp_rdata SHALL be 0, and resp_err SHALL be 1; timing SHALL be unchanged.
REQ-026 req_be SHALL be ignored for reads; a write with req_be=0 SHALL complete normally with no data change.
REQ-027 Write responses SHALL return resp_rdata=0 and resp_err=0 when in range.

Reset
REQ-028 While rst=0, the FSM SHALL be in IDLE, the counter 0, resp_valid 0, resp_rdata 0, and resp_err 0, and req_ready SHALL be forced to 0; req_ready SHALL be 1 on the first cycle after release.
REQ-029 Reset asserted in WAIT SHALL abort the transaction without a RAM write.
REQ-030 Reset asserted in RESP SHALL drop the response; no RAM write is pending at that point.
REQ-031 RAM contents SHALL NOT be reset; only the control state is cleared.

Verification
REQ-032 The bench SHALL cover: with WAIT_CYCLES=2, write 0x12345678 to 0x10 with be=F, then read 0x10 -> resp_valid 3 cycles after acceptance, rdata=0x12345678, err=0.
REQ-033 The bench SHALL cover: after REQ-032, write 0xAABBCCDD to 0x10 with be=0010b, then read 0x10 -> rdata=0x1234CC78.
REQ-034 The bench SHALL cover: read 0x12 -> err=1, rdata=0; write 0xFFFFFFFF to 0x400 (DEPTH 256) -> err=1; read 0x0 is unchanged.
REQ-035 The bench SHALL cover: hold resp_ready=0 for 5 cycles during a read response -> resp_valid and rdata stable, req_ready=0, and a concurrent req_valid is not accepted; resp_ready=1 -> IDLE on the next cycle.
REQ-036 The bench SHALL cover: write 0x55 to 0x20 with rst pulsed low during WAIT -> outputs go to reset values immediately; a subsequent read of 0x20 returns the prior value.
REQ-037 The bench SHALL cover: with WAIT_CYCLES=0, back-to-back reads with resp_ready=1 -> resp_valid 1 cycle after each acceptance, one transaction every 2 cycles.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Single-outstanding memory responder with a word-wide backing RAM.
// Each accepted request waits WAIT_CYCLES states, then performs its RAM
// access and holds a registered response until the initiator consumes it.
// Misaligned or out-of-range addresses complete with resp_err=1 and have
// no effect on the RAM.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          AW         = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Address is unusable when not word aligned or beyond the RAM.
   function automatic logic addr_is_bad(input logic [31:0] addr);
      addr_is_bad = (addr[1:0] != 2'b00) || ({1'b0, addr} >= ADDR_LIMIT);
   endfunction

   // Replace only the enabled bytes of the stored word.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res;
   endfunction

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic          accept_s;
   logic          enter_resp_s;
   logic          acc_we_s;
   logic [31:0]   acc_addr_s;
   logic [31:0]   acc_wdata_s;
   logic [3:0]    acc_be_s;
   logic [AW-1:0] acc_idx_s;
   logic [31:0]   rd_word_s;
   logic          fill_err_s;
   logic [31:0]   fill_rdata_s;
   logic          ram_we_s;

   // Ready only while idle and out of reset.
   assign req_ready = (state_q == S_IDLE) && rst;
   assign accept_s  = req_valid && req_ready;

   // Access fields: live request when entering RESP straight from IDLE
   // (zero wait states), otherwise the captured request.
   always_comb begin
      acc_we_s    = we_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
      acc_be_s    = be_q;
      if (state_q == S_IDLE) begin
         acc_we_s    = req_we;
         acc_addr_s  = req_addr;
         acc_wdata_s = req_wdata;
         acc_be_s    = req_be;
      end else begin
         acc_we_s    = we_q;
         acc_addr_s  = addr_q;
         acc_wdata_s = wdata_q;
         acc_be_s    = be_q;
      end
   end

   assign acc_idx_s = acc_addr_s[AW+1:2];
   assign rd_word_s = mem_q[acc_idx_s];

   // Response payload computed for the access that enters RESP.
   always_comb begin
      fill_err_s   = addr_is_bad(acc_addr_s);
      fill_rdata_s = 32'h0000_0000;
      if (!acc_we_s && !fill_err_s) begin
         fill_rdata_s = rd_word_s;
      end else begin
         fill_rdata_s = 32'h0000_0000;
      end
   end

   assign ram_we_s = enter_resp_s && acc_we_s && !fill_err_s;

   // Next-state, request capture and response register update.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      enter_resp_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = WAIT_INIT;
               if (WAIT_INIT == 4'd0) begin
                  state_d      = S_RESP;
                  cnt_d        = 4'd0;
                  enter_resp_s = 1'b1;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = fill_rdata_s;
                  resp_err_d   = fill_err_s;
               end else begin
                  state_d = S_WAIT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d      = S_RESP;
               cnt_d        = 4'd0;
               enter_resp_s = 1'b1;
               resp_valid_d = 1'b1;
               resp_rdata_d = fill_rdata_s;
               resp_err_d   = fill_err_s;
            end else begin
               state_d = S_WAIT;
               cnt_d   = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d      = S_IDLE;
               resp_valid_d = 1'b0;
               resp_rdata_d = 32'h0000_0000;
               resp_err_d   = 1'b0;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d      = S_IDLE;
            cnt_d        = 4'd0;
            resp_valid_d = 1'b0;
            resp_rdata_d = 32'h0000_0000;
            resp_err_d   = 1'b0;
         end
      endcase
   end

   // Control and response registers; cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         we_q         <= 1'b0;
         addr_q       <= 32'h0000_0000;
         wdata_q      <= 32'h0000_0000;
         be_q         <= 4'h0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Backing RAM: contents survive reset; written only on entry to RESP.
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         mem_q[acc_idx_s] <= merge_bytes(rd_word_s, acc_wdata_s, acc_be_s);
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with two wait states and one
// with none, selected by 'sel'; outcomes compared with a word-array model.
module tb_data_mem_responder;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_ready;
   int          sel;

   logic        valid_w2, valid_w0;
   logic        ready_w2, ready_w0;
   logic        rvalid_w2, rvalid_w0;
   logic [31:0] rdata_w2, rdata_w0;
   logic        err_w2, err_w0;
   logic        obs_ready, obs_valid, obs_err;
   logic [31:0] obs_rdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [31:0] model_mem [2][DEPTH];

   always #5 clk = ~clk;

   // Free-running cycle count for acceptance timing.
   always @(posedge clk) cyc <= cyc + 1;

   assign valid_w2  = req_valid && (sel == 0);
   assign valid_w0  = req_valid && (sel == 1);
   assign obs_ready = (sel == 1) ? ready_w0  : ready_w2;
   assign obs_valid = (sel == 1) ? rvalid_w0 : rvalid_w2;
   assign obs_rdata = (sel == 1) ? rdata_w0  : rdata_w2;
   assign obs_err   = (sel == 1) ? err_w0    : err_w2;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
      .clk(clk), .rst(rst), .req_valid(valid_w2), .req_ready(ready_w2),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(rvalid_w2), .resp_ready(resp_ready), .resp_rdata(rdata_w2),
      .resp_err(err_w2));

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst), .req_valid(valid_w0), .req_ready(ready_w0),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(rvalid_w0), .resp_ready(resp_ready), .resp_rdata(rdata_w0),
      .resp_err(err_w0));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // One full transaction; hold = cycles the response is left unconsumed
   // while a competing request is offered.
   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold,
                         output logic [31:0] got, output int acc_cyc);
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          lat;
      int          guard;
      int          wexp;
      wexp      = (sel == 1) ? 0 : 2;
      exp_err   = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
      exp_rdata = (!we && !exp_err) ? model_mem[sel][addr[9:2]] : 32'h0;
      guard = 0;
      while (obs_ready !== 1'b1 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check_val("ready_idle", 32'(obs_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      @(posedge clk); #1;
      acc_cyc   = cyc;
      req_valid = 1'b0;
      lat = 1;
      while (obs_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val("latency", 32'(lat), 32'(wexp + 1));
      check_val("rdata", obs_rdata, exp_rdata);
      check_val("err", 32'(obs_err), 32'(exp_err));
      got = obs_rdata;
      if (we && !exp_err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) model_mem[sel][addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
         end
      end
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_wdata = $urandom;
         req_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         @(posedge clk); #1;
         check_val("hold_valid", 32'(obs_valid), 32'd1);
         check_val("hold_rdata", obs_rdata, exp_rdata);
         check_val("hold_ready", 32'(obs_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check_val("done_valid", 32'(obs_valid), 32'd0);
      check_val("done_rdata", obs_rdata, 32'h0);
      check_val("done_err", 32'(obs_err), 32'd0);
      check_val("done_ready", 32'(obs_ready), 32'd1);
   endtask

   task automatic rand_txns(input int n);
      logic [31:0] a;
      logic [31:0] got;
      int          ac;
      int          r;
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         else if (r == 7) a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
         else             a = $urandom | 32'h0000_0400;
         do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), got, ac);
      end
   endtask

   task automatic fill_mem();
      logic [31:0] got;
      int          ac;
      for (int i = 0; i < DEPTH; i++) begin
         do_txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, got, ac);
      end
   endtask

   // Bound on total run time.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      int          ac;
      int          prev_ac;
      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
      req_wdata = 32'h0; req_be = 4'h0; resp_ready = 1'b0; sel = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_ready", 32'(obs_ready), 32'd0);
      check_val("rst_valid", 32'(obs_valid), 32'd0);
      check_val("rst_rdata", obs_rdata, 32'h0);
      check_val("rst_err", 32'(obs_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_val("rel_ready", 32'(obs_ready), 32'd1);

      // Two-wait-state instance
      fill_mem();
      do_txn(1'b1, 32'h10, 32'h1234_5678, 4'hF, 0, got, ac);
      do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, got, ac);
      check_val("rd_full_word", got, 32'h1234_5678);
      do_txn(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0010, 0, got, ac);
      do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, got, ac);
      check_val("rd_byte1_merge", got, 32'h1234_CC78);
      do_txn(1'b1, 32'h14, 32'hDEAD_BEEF, 4'h0, 0, got, ac);
      do_txn(1'b0, 32'h14, 32'h0, 4'h0, 0, got, ac);
      do_txn(1'b0, 32'h12, 32'h0, 4'h0, 0, got, ac);
      do_txn(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 0, got, ac);
      do_txn(1'b0, 32'h0, 32'h0, 4'h0, 0, got, ac);
      do_txn(1'b0, 32'h3FC, 32'h0, 4'h0, 0, got, ac);
      do_txn(1'b0, 32'h3FD, 32'h0, 4'h0, 0, got, ac);
      do_txn(1'b0, 32'h40, 32'h0, 4'h0, 5, got, ac);

      // Reset pulse while a write waits
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_val("abort_ready", 32'(obs_ready), 32'd0);
      check_val("abort_valid", 32'(obs_valid), 32'd0);
      check_val("abort_rdata", obs_rdata, 32'h0);
      check_val("abort_err", 32'(obs_err), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_val("abort_no_resp", 32'(obs_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_val("abort_rel_ready", 32'(obs_ready), 32'd1);
      do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, got, ac);
      check_val("abort_kept", got, model_mem[0][8]);

      rand_txns(150);

      // Zero-wait-state instance
      sel = 1;
      fill_mem();
      prev_ac = 0;
      for (int i = 0; i < 16; i++) begin
         do_txn(1'b0, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0, 4'h0, 0, got, ac);
         if (i > 0) check_val("b2b_period", 32'(ac - prev_ac), 32'd2);
         prev_ac = ac;
      end
      rand_txns(150);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
